// File: rtl/calc_sequencer.sv
// Calculator operation sequencer: operand-1 entry, operand-2 entry, result display.
// Optional result chaining is enabled with the CALC_RESULT_CHAIN_EN macro.
module calc_sequencer #(
  parameter int unsigned WIDTH        = 14,
  parameter int unsigned IDLE_TIMEOUT = 2**30,
  parameter int unsigned CNT_W        = 31
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_clr,
  input  logic             btn_add,
  input  logic             btn_sub,
  input  logic             btn_ent,
  input  logic [WIDTH-1:0] result,
  output logic             write_number_select,
  output logic             arithmetic_sel,
  output logic [1:0]       display_select,
  output logic             clear_operands,
  output logic             load_result,
  output logic [WIDTH-1:0] load_value,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    StA       = 2'd0,
    StB       = 2'd1,
    StIllegal = 2'd2,
    StRes     = 2'd3
  } state_e;

  localparam logic             TimeoutEn = (IDLE_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CntLast   = CNT_W'(IDLE_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic             sel_q, sel_d;
  logic             wns_q, wns_d;
  logic             clr_q, clr_d;
  logic             ld_q, ld_d;
  logic [WIDTH-1:0] lv_q, lv_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             any_btn;

  assign any_btn = btn_clr | btn_add | btn_sub | btn_ent;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    clr_d   = 1'b0;
    ld_d    = 1'b0;
    lv_d    = lv_q;
    cnt_d   = cnt_q;
    if (btn_clr) begin
      state_d = StA;
      clr_d   = 1'b1;
      sel_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        StA, StB: begin
          // Subtract wins when both operator buttons arrive together.
          if (btn_sub) begin
            sel_d = 1'b1;
          end else if (btn_add) begin
            sel_d = 1'b0;
          end
          if (btn_ent) begin
            state_d = (state_q == StA) ? StB : StRes;
          end
        end
        StRes: begin
          if (btn_ent) begin
`ifdef CALC_RESULT_CHAIN_EN
            state_d = StB;
            ld_d    = 1'b1;
            lv_d    = result;
`else
            state_d = StA;
            clr_d   = 1'b1;
`endif
          end
        end
        default: state_d = StA;
      endcase

      if (state_q == StB || state_q == StRes) begin
        if (any_btn) begin
          cnt_d = '0;
        end else if (TimeoutEn && cnt_q == CntLast) begin
          state_d = StA;
          clr_d   = 1'b1;
          cnt_d   = '0;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        cnt_d = '0;
      end
    end
    wns_d = (state_d == StB);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StA;
      sel_q   <= 1'b0;
      wns_q   <= 1'b0;
      clr_q   <= 1'b0;
      ld_q    <= 1'b0;
      lv_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      wns_q   <= wns_d;
      clr_q   <= clr_d;
      ld_q    <= ld_d;
      lv_q    <= lv_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state               = state_q;
  assign display_select      = state_q;
  assign write_number_select = wns_q;
  assign arithmetic_sel      = sel_q;
  assign clear_operands      = clr_q;

`ifdef CALC_RESULT_CHAIN_EN
  assign load_result = ld_q;
  assign load_value  = lv_q;
`else
  // Chaining disabled: load path tied off, result only feeds the display.
  logic unused_load;
  assign unused_load = ld_q ^ (^lv_q) ^ (^result);
  assign load_result = 1'b0;
  assign load_value  = '0;
`endif

endmodule

// File: tb/tb_calc_sequencer.sv
// Scoreboard bench for calc_sequencer: driver queues expected outputs per clock edge,
// a monitor pops and compares them after each edge. Honours CALC_RESULT_CHAIN_EN.
module tb_calc_sequencer;
  localparam int W = 14;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         btn_clr = 1'b0, btn_add = 1'b0, btn_sub = 1'b0, btn_ent = 1'b0;
  logic [W-1:0] result = '0;
  logic         write_number_select, arithmetic_sel, clear_operands, load_result;
  logic [1:0]   display_select, state;
  logic [W-1:0] load_value;

  calc_sequencer #(
    .WIDTH       (W),
    .IDLE_TIMEOUT(16),
    .CNT_W       (31)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .btn_clr            (btn_clr),
    .btn_add            (btn_add),
    .btn_sub            (btn_sub),
    .btn_ent            (btn_ent),
    .result             (result),
    .write_number_select(write_number_select),
    .arithmetic_sel     (arithmetic_sel),
    .display_select     (display_select),
    .clear_operands     (clear_operands),
    .load_result        (load_result),
    .load_value         (load_value),
    .state              (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           cyc;
    string        name;
    logic [1:0]   st;
    logic         sel;
    logic         clr;
    logic         ld;
    logic [W-1:0] lv;
  } exp_t;

  exp_t         q[$];
  int           cyc = 0;
  int           tag = 0;
  int           n_tests = 0;
  int           n_fail = 0;
  logic [W-1:0] exp_lv = '0;

  task automatic check(input exp_t e);
    logic [W+7:0] got, want;
    got  = {state, display_select, write_number_select, arithmetic_sel,
            clear_operands, load_result, load_value};
    want = {e.st, e.st, (e.st == 2'd1), e.sel, e.clr, e.ld, e.lv};
    n_tests++;
    if (e.cyc != cyc || got !== want) begin
      n_fail++;
      $display("FAIL %s @cyc %0d (exp cyc %0d): got st=%0d ds=%0d wns=%0b sel=%0b clr=%0b ld=%0b lv=%0d, want st=%0d ds=%0d wns=%0b sel=%0b clr=%0b ld=%0b lv=%0d",
               e.name, cyc, e.cyc, state, display_select, write_number_select, arithmetic_sel,
               clear_operands, load_result, load_value, e.st, e.st, (e.st == 2'd1), e.sel,
               e.clr, e.ld, e.lv);
    end
  endtask

  // Monitor: sample 1 time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front();
        check(e);
      end
    end
  end

  task automatic step(input logic c, input logic a, input logic s, input logic e);
    @(negedge clk);
    btn_clr = c;
    btn_add = a;
    btn_sub = s;
    btn_ent = e;
    tag     = cyc + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic exp_out(input string name, input logic [1:0] st, input logic sel,
                         input logic clr, input logic ld, input logic [W-1:0] lv);
    exp_t e;
    e.cyc  = tag;
    e.name = name;
    e.st   = st;
    e.sel  = sel;
    e.clr  = clr;
    e.ld   = ld;
    e.lv   = lv;
    q.push_back(e);
  endtask

  // Enter in S_RES, then the cycle after it.
  task automatic res_ent(input string name, input logic sel);
    step(1'b0, 1'b0, 1'b0, 1'b1);
`ifdef CALC_RESULT_CHAIN_EN
    exp_lv = result;
    exp_out(name, 2'd1, sel, 1'b0, 1'b1, exp_lv);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    exp_out({name, "_after"}, 2'd1, sel, 1'b0, 1'b0, exp_lv);
`else
    exp_out(name, 2'd0, sel, 1'b1, 1'b0, exp_lv);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    exp_out({name, "_after"}, 2'd0, sel, 1'b0, 1'b0, exp_lv);
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    result = 14'd1234;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    step(0, 0, 0, 0); exp_out("reset", 2'd0, 0, 0, 0, exp_lv);

    // Enter sequence through all three states.
    step(0, 0, 0, 1); exp_out("ent1", 2'd1, 0, 0, 0, exp_lv);
    idle(4);
    step(0, 0, 0, 1); exp_out("ent2", 2'd3, 0, 0, 0, exp_lv);
    idle(4);
    res_ent("ent3", 1'b0);
    step(1, 0, 0, 0); exp_out("clr_a", 2'd0, 0, 1, 0, exp_lv);
    step(0, 0, 0, 0); exp_out("clr_a_end", 2'd0, 0, 0, 0, exp_lv);

    // Operator selection and S_RES freeze.
    step(0, 0, 1, 0); exp_out("sub_a", 2'd0, 1, 0, 0, exp_lv);
    step(0, 1, 0, 0); exp_out("add_a", 2'd0, 0, 0, 0, exp_lv);
    step(0, 1, 1, 0); exp_out("both_a", 2'd0, 1, 0, 0, exp_lv);
    step(0, 0, 0, 1); exp_out("to_b", 2'd1, 1, 0, 0, exp_lv);
    step(0, 0, 0, 1); exp_out("to_res", 2'd3, 1, 0, 0, exp_lv);
    step(0, 1, 0, 0); exp_out("res_frozen", 2'd3, 1, 0, 0, exp_lv);
    result = 14'd777;
    res_ent("ent_res2", 1'b1);
    step(1, 0, 0, 0); exp_out("clr2", 2'd0, 0, 1, 0, exp_lv);
    step(0, 0, 0, 0); exp_out("clr2_end", 2'd0, 0, 0, 0, exp_lv);

    // S_B: operator edits, clear priority, enter+sub together.
    step(0, 0, 0, 1); exp_out("b2", 2'd1, 0, 0, 0, exp_lv);
    step(0, 0, 1, 0); exp_out("sub_b", 2'd1, 1, 0, 0, exp_lv);
    step(0, 1, 0, 0); exp_out("add_b", 2'd1, 0, 0, 0, exp_lv);
    step(1, 0, 1, 1); exp_out("clr_ent", 2'd0, 0, 1, 0, exp_lv);
    step(0, 0, 0, 0); exp_out("clr_ent_end", 2'd0, 0, 0, 0, exp_lv);
    step(0, 0, 0, 1); exp_out("b3", 2'd1, 0, 0, 0, exp_lv);
    step(0, 0, 1, 1); exp_out("sub_ent", 2'd3, 1, 0, 0, exp_lv);
    step(1, 0, 0, 0); exp_out("clr3", 2'd0, 0, 1, 0, exp_lv);
    step(0, 0, 0, 0); exp_out("clr3_end", 2'd0, 0, 0, 0, exp_lv);

    // Inactivity timeout of 16 cycles in S_B.
    step(0, 0, 0, 1); exp_out("to_b_idle", 2'd1, 0, 0, 0, exp_lv);
    idle(14);
    step(0, 0, 0, 0); exp_out("pre_timeout", 2'd1, 0, 0, 0, exp_lv);
    step(0, 0, 0, 0); exp_out("timeout", 2'd0, 0, 1, 0, exp_lv);
    step(0, 0, 0, 0); exp_out("timeout_end", 2'd0, 0, 0, 0, exp_lv);

    // A pulse at cycle 10 restarts the count; sel survives the timeout.
    step(0, 0, 1, 0); exp_out("sub_a2", 2'd0, 1, 0, 0, exp_lv);
    step(0, 0, 0, 1); exp_out("to_b_idle2", 2'd1, 1, 0, 0, exp_lv);
    idle(9);
    step(0, 0, 1, 0); exp_out("restart", 2'd1, 1, 0, 0, exp_lv);
    idle(14);
    step(0, 0, 0, 0); exp_out("no_timeout_yet", 2'd1, 1, 0, 0, exp_lv);
    step(0, 0, 0, 0); exp_out("timeout2", 2'd0, 1, 1, 0, exp_lv);
    step(0, 0, 0, 0); exp_out("timeout2_end", 2'd0, 1, 0, 0, exp_lv);

    // Asynchronous reset mid-operation with a pending enter pulse.
    step(0, 0, 0, 1); exp_out("b_rst", 2'd1, 1, 0, 0, exp_lv);
    @(negedge clk);
    btn_ent = 1'b1;
    reset   = 1'b0;
    #1;
    n_tests++;
    if (state !== 2'd0 || arithmetic_sel !== 1'b0 || write_number_select !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got st=%0d sel=%0b wns=%0b, want st=0 sel=0 wns=0",
               state, arithmetic_sel, write_number_select);
    end
    exp_lv = '0;
    tag    = cyc + 1;
    exp_out("reset_mid", 2'd0, 0, 0, 0, exp_lv);
    @(negedge clk);
    btn_ent = 1'b0;
    reset   = 1'b1;
    step(0, 0, 0, 0); exp_out("post_reset", 2'd0, 0, 0, 0, exp_lv);

    repeat (3) @(posedge clk);
    #2;
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: got %0d pending expectations, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
